// File: rtl/uart_ctrl_reg.sv
// Purpose : host write-side UART TX control register; config bits, TX holding FIFO, launch FSM.
// Latency : writes visible after the sampling edge; a byte pushed at edge k pops at k+1, start pulse follows.
// Backpr. : push into a full FIFO with no pop on that edge is dropped and flags tx_overflow.
// Ports   : clk/arst_n (sync, active-low); we/wmask/wdata host write; ovf_clr clears stickies;
//           tnsm_busy/tnsm_start/tnsm_data transmitter handshake; parity_en/parity_odd/loopback config;
//           fifo_empty/fifo_full/fifo_level occupancy; tx_overflow/ack_timeout sticky errors.
module uart_ctrl_reg #(
  parameter int FIFO_DEPTH  = 4,
  parameter int ACK_TIMEOUT = 8,
  localparam int LVL_W      = $clog2(FIFO_DEPTH) + 1
) (
  input  logic             clk,
  input  logic             arst_n,
  input  logic             we,
  input  logic [11:0]      wmask,
  input  logic [11:0]      wdata,
  input  logic             ovf_clr,
  input  logic             tnsm_busy,
  output logic             tnsm_start,
  output logic [7:0]       tnsm_data,
  output logic             parity_en,
  output logic             parity_odd,
  output logic             loopback,
  output logic             fifo_empty,
  output logic             fifo_full,
  output logic [LVL_W-1:0] fifo_level,
  output logic             tx_overflow,
  output logic             ack_timeout
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = $clog2(ACK_TIMEOUT + 1);

  typedef enum logic [1:0] {IDLE, WAIT_BUSY, WAIT_DONE} state_t;

  state_t           state;
  logic [7:0]       mem [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] cnt;

  logic             push_req;
  logic             push_ok;
  logic             pop;
  logic             ovf_set;
  logic             ack_set;
  logic [LVL_W-1:0] lvl_next;

  // Byte-field mask bits have no effect on the tx byte; tie them off explicitly.
  logic unused_wmask;
  assign unused_wmask = ^wmask[7:0];

  assign push_req = we && wmask[8] && wdata[8];
  assign pop      = (state == IDLE) && !fifo_empty && !tnsm_busy;
  // A pop on the same edge frees the slot the push needs, so a full FIFO still accepts.
  assign push_ok  = push_req && (!fifo_full || pop);
  assign ovf_set  = push_req && fifo_full && !pop;
  // cnt holds the WAIT_BUSY cycles already elapsed after the start cycle; this edge ends cycle cnt+1.
  assign ack_set  = (state == WAIT_BUSY) && !tnsm_busy && (cnt == CNT_W'(ACK_TIMEOUT - 1));

  always_comb begin
    lvl_next = fifo_level;
    if (push_ok && !pop)
      lvl_next = fifo_level + LVL_W'(1);
    else if (pop && !push_ok)
      lvl_next = fifo_level - LVL_W'(1);
  end

  // Storage is not reset; occupancy is owned by the pointers and level.
  always_ff @(posedge clk) begin
    if (arst_n && push_ok)
      mem[wr_ptr] <= wdata[7:0];
  end

  always_ff @(posedge clk) begin
    if (!arst_n) begin
      state       <= IDLE;
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      cnt         <= '0;
      fifo_level  <= '0;
      fifo_empty  <= 1'b1;
      fifo_full   <= 1'b0;
      tnsm_start  <= 1'b0;
      tnsm_data   <= '0;
      parity_en   <= 1'b0;
      parity_odd  <= 1'b0;
      loopback    <= 1'b0;
      tx_overflow <= 1'b0;
      ack_timeout <= 1'b0;
    end else begin
      if (we) begin
        if (wmask[9])  parity_en  <= wdata[9];
        if (wmask[10]) parity_odd <= wdata[10];
        if (wmask[11]) loopback   <= wdata[11];
      end

      if (push_ok) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)     rd_ptr <= rd_ptr + PTR_W'(1);
      fifo_level <= lvl_next;
      fifo_empty <= (lvl_next == '0);
      fifo_full  <= (lvl_next == LVL_W'(FIFO_DEPTH));

      // Set beats clear when both land on the same edge.
      tx_overflow <= ovf_set || (tx_overflow && !ovf_clr);
      ack_timeout <= ack_set || (ack_timeout && !ovf_clr);

      tnsm_start <= 1'b0;
      case (state)
        IDLE: begin
          if (pop) begin
            tnsm_data  <= mem[rd_ptr];
            tnsm_start <= 1'b1;
            cnt        <= '0;
            state      <= WAIT_BUSY;
          end
        end
        WAIT_BUSY: begin
          if (tnsm_busy)
            state <= WAIT_DONE;
          else if (ack_set)
            state <= IDLE;  // byte is abandoned
          else
            cnt <= cnt + CNT_W'(1);
        end
        WAIT_DONE: begin
          if (!tnsm_busy)
            state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_ctrl_reg.sv
// Purpose : self-checking bench for uart_ctrl_reg with a simple transmitter model.
// Latency : n/a (bench).
// Backpr. : n/a (bench).
module tb_uart_ctrl_reg;

  logic        clk = 1'b0;
  logic        arst_n;
  logic        we;
  logic [11:0] wmask;
  logic [11:0] wdata;
  logic        ovf_clr;
  logic        busy_force;
  logic        model_busy = 1'b0;
  logic        tnsm_busy;
  logic        tnsm_start;
  logic [7:0]  tnsm_data;
  logic        parity_en, parity_odd, loopback;
  logic        fifo_empty, fifo_full;
  logic [2:0]  fifo_level;
  logic        tx_overflow, ack_timeout;

  logic        tx_auto = 1'b0;
  int          mdl_cnt = 0;
  logic [7:0]  launched [$];
  int          dbl_pulse = 0;
  logic        prev_start = 1'b0;

  int n_checks = 0;
  int n_err    = 0;

  assign tnsm_busy = busy_force | model_busy;

  always #5 clk = ~clk;

  uart_ctrl_reg #(.FIFO_DEPTH(4), .ACK_TIMEOUT(8)) dut (
    .clk        (clk),
    .arst_n     (arst_n),
    .we         (we),
    .wmask      (wmask),
    .wdata      (wdata),
    .ovf_clr    (ovf_clr),
    .tnsm_busy  (tnsm_busy),
    .tnsm_start (tnsm_start),
    .tnsm_data  (tnsm_data),
    .parity_en  (parity_en),
    .parity_odd (parity_odd),
    .loopback   (loopback),
    .fifo_empty (fifo_empty),
    .fifo_full  (fifo_full),
    .fifo_level (fifo_level),
    .tx_overflow(tx_overflow),
    .ack_timeout(ack_timeout)
  );

  // Transmitter: busy rises the cycle after a start pulse and stays high 10 cycles.
  always @(posedge clk) begin
    if (!tx_auto) begin
      mdl_cnt    <= 0;
      model_busy <= 1'b0;
    end else if (mdl_cnt > 0) begin
      mdl_cnt <= mdl_cnt - 1;
      if (mdl_cnt == 1) model_busy <= 1'b0;
    end else if (tnsm_start === 1'b1) begin
      mdl_cnt    <= 10;
      model_busy <= 1'b1;
    end
  end

  // Launch log and back-to-back start detector.
  always @(posedge clk) begin
    if (tnsm_start === 1'b1) begin
      launched.push_back(tnsm_data);
      if (prev_start) dbl_pulse++;
    end
    prev_start <= (tnsm_start === 1'b1);
  end

  typedef struct {
    logic        we;
    logic [11:0] wmask;
    logic [11:0] wdata;
    logic        clr;
    logic [2:0]  exp_lvl;
    logic [6:0]  exp_flg;  // {full, empty, parity_en, parity_odd, loopback, tx_overflow, tnsm_start}
  } vec_t;

  vec_t vecs [14];

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic write(input logic [11:0] m, input logic [11:0] d);
    we = 1'b1; wmask = m; wdata = d;
    step();
    we = 1'b0; wmask = '0; wdata = '0;
  endtask

  task automatic chk_reset(input string name);
    chk(name, {14'd0, tnsm_start, tnsm_data, parity_en, parity_odd, loopback,
               fifo_empty, fifo_full, fifo_level, tx_overflow, ack_timeout},
        {14'd0, 1'b0, 8'h00, 3'b000, 1'b1, 1'b0, 3'd0, 2'b00});
  endtask

  initial begin
    vecs[0]  = '{1'b1, 12'hA00, 12'hE00, 1'b0, 3'd0, 7'b0110100};
    vecs[1]  = '{1'b1, 12'h400, 12'h400, 1'b0, 3'd0, 7'b0111100};
    vecs[2]  = '{1'b1, 12'hE00, 12'h000, 1'b0, 3'd0, 7'b0100000};
    vecs[3]  = '{1'b1, 12'h100, 12'h101, 1'b0, 3'd1, 7'b0000000};
    vecs[4]  = '{1'b1, 12'h100, 12'h102, 1'b0, 3'd2, 7'b0000000};
    vecs[5]  = '{1'b1, 12'h0FF, 12'h1FF, 1'b0, 3'd2, 7'b0000000};
    vecs[6]  = '{1'b1, 12'h100, 12'h003, 1'b0, 3'd2, 7'b0000000};
    vecs[7]  = '{1'b0, 12'hFFF, 12'hFFF, 1'b0, 3'd2, 7'b0000000};
    vecs[8]  = '{1'b1, 12'h300, 12'h303, 1'b0, 3'd3, 7'b0010000};
    vecs[9]  = '{1'b1, 12'h100, 12'h104, 1'b0, 3'd4, 7'b1010000};
    vecs[10] = '{1'b1, 12'h100, 12'h105, 1'b0, 3'd4, 7'b1010010};
    vecs[11] = '{1'b0, 12'h000, 12'h000, 1'b1, 3'd4, 7'b1010000};
    vecs[12] = '{1'b1, 12'h100, 12'h106, 1'b1, 3'd4, 7'b1010010};
    vecs[13] = '{1'b0, 12'h000, 12'h000, 1'b1, 3'd4, 7'b1010000};

    arst_n = 1'b0; we = 1'b0; wmask = '0; wdata = '0; ovf_clr = 1'b0; busy_force = 1'b0;
    repeat (2) step();
    chk_reset("reset_init");
    arst_n = 1'b1;
    step();

    // Single send with the transmitter model answering.
    tx_auto = 1'b1;
    launched.delete();
    write(12'h100, 12'h1A5);
    chk("send_lvl_after_push", {28'd0, tnsm_start, fifo_level}, {28'd0, 1'b0, 3'd1});
    step();
    chk("send_start_pulse", {20'd0, tnsm_start, tnsm_data, fifo_level}, {20'd0, 1'b1, 8'hA5, 3'd0});
    step();
    chk("send_start_low", {31'd0, tnsm_start}, 32'd0);
    repeat (15) step();
    chk("send_done", {23'd0, ack_timeout, fifo_empty, launched.size() == 1 ? launched[0] : 8'hFF},
        {23'd0, 1'b0, 1'b1, 8'hA5});

    // Table: config masking, push gating, fill, overflow, clear vs set.
    tx_auto = 1'b0;
    busy_force = 1'b1;
    step();
    for (int i = 0; i < 14; i++) begin
      we = vecs[i].we; wmask = vecs[i].wmask; wdata = vecs[i].wdata; ovf_clr = vecs[i].clr;
      step();
      chk($sformatf("vec%0d", i),
          {22'd0, fifo_level, fifo_full, fifo_empty, parity_en, parity_odd, loopback, tx_overflow, tnsm_start},
          {22'd0, vecs[i].exp_lvl, vecs[i].exp_flg});
    end
    we = 1'b0; wmask = '0; wdata = '0; ovf_clr = 1'b0;

    // Drain: 0x01..0x04 in order, dropped bytes absent.
    launched.delete();
    tx_auto = 1'b1;
    busy_force = 1'b0;
    repeat (70) step();
    chk("drain_count", launched.size(), 32'd4);
    for (int i = 0; i < 4; i++)
      chk($sformatf("drain_byte%0d", i), (i < launched.size()) ? {24'd0, launched[i]} : 32'hFFFF, i + 1);
    chk("drain_empty", {28'd0, fifo_empty, fifo_level}, {28'd0, 1'b1, 3'd0});

    // Push at full on the same edge as a launch.
    busy_force = 1'b1;
    step();
    write(12'h100, 12'h111);
    write(12'h100, 12'h122);
    write(12'h100, 12'h133);
    write(12'h100, 12'h144);
    chk("simul_prefill", {28'd0, fifo_full, fifo_level}, {28'd0, 1'b1, 3'd4});
    launched.delete();
    busy_force = 1'b0;
    write(12'h100, 12'h177);
    chk("simul_edge", {19'd0, fifo_level, tx_overflow, fifo_full, tnsm_start, tnsm_data},
        {19'd0, 3'd4, 1'b0, 1'b1, 1'b1, 8'h11});
    repeat (80) step();
    chk("simul_count", launched.size(), 32'd5);
    chk("simul_order", launched.size() == 5 ?
        {launched[1], launched[2], launched[3], launched[4]} : 32'hFFFF_FFFF, 32'h22334477);

    // Ack timeout.
    tx_auto = 1'b0;
    step();
    write(12'h100, 12'h13C);
    step();
    chk("to_start", {23'd0, tnsm_start, tnsm_data}, {23'd0, 1'b1, 8'h3C});
    repeat (7) step();
    chk("to_not_yet", {31'd0, ack_timeout}, 32'd0);
    step();
    chk("to_set", {31'd0, ack_timeout}, 32'd1);
    tx_auto = 1'b1;
    write(12'h100, 12'h15A);
    step();
    chk("to_back_idle", {23'd0, tnsm_start, tnsm_data}, {23'd0, 1'b1, 8'h5A});
    ovf_clr = 1'b1;
    step();
    ovf_clr = 1'b0;
    chk("to_cleared", {31'd0, ack_timeout}, 32'd0);

    // Reset mid-traffic.
    repeat (20) step();
    busy_force = 1'b1;
    write(12'hE00, 12'hE00);
    for (int i = 0; i < 5; i++) write(12'h100, 12'h1C0 | 12'(i));
    chk("rst_pre", {29'd0, tx_overflow, loopback, fifo_full}, {29'd0, 3'b111});
    busy_force = 1'b0;
    step();
    chk("rst_mid_launch", {31'd0, tnsm_start}, 32'd1);
    arst_n = 1'b0;
    step();
    step();
    chk_reset("reset_mid");
    arst_n = 1'b1;
    launched.delete();
    repeat (5) step();
    chk("rst_no_start", launched.size(), 32'd0);
    chk_reset("reset_after");

    chk("no_double_start", dbl_pulse, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule

// File: doc/uart_ctrl_reg.md
# uart_ctrl_reg

Host-facing write-side control register for the UART transmit path. It is the counterpart of the receive status register. It accepts masked host writes, holds line configuration bits, and buffers transmit bytes in a small FIFO. A launch state machine hands each byte to the transmitter with a start pulse and tracks the transmitter's busy signal until the byte completes.

## Interface
Parameters:
- FIFO_DEPTH, 4, transmit holding FIFO depth; power of two, ≥2
- LVL_W, $clog2(FIFO_DEPTH)+1, width of fifo_level (derived, not overridable)
- ACK_TIMEOUT, 8, cycles to wait in WAIT_BUSY for tnsm_busy to rise

Ports:
- clk  in  1  clock; all logic on rising edge
- arst_n  in  1  reset; synchronous, active-low
- we  in  1  host write enable; sampled each rising edge
- wmask  in  12  per-bit write mask; a field is affected only where its mask bit is 1
- wdata  in  12  write data. [7:0] tx byte; [8] send; [9] parity_en; [10] parity_odd; [11] loopback
- ovf_clr  in  1  clears tx_overflow
- tnsm_busy  in  1  transmitter busy
- tnsm_start  out  1  one-cycle start pulse to transmitter
- tnsm_data  out  8  byte being launched
- parity_en, parity_odd, loopback  out  1 each  configuration bits
- fifo_empty  out  1  FIFO holds 0 entries
- fifo_full  out  1  FIFO holds FIFO_DEPTH entries
- fifo_level  out  LVL_W  occupancy 0..FIFO_DEPTH
- tx_overflow  out  1  sticky: push attempted while full
- ack_timeout  out  1  sticky: WAIT_BUSY timed out; cleared by ovf_clr

## Operation
- **Config bits.** On a `we` edge, bits 9/10/11 load wdata[9/10/11] where the matching wmask bit is 1. Otherwise they hold. wmask[7:0] is ignored.
- **Push.** A push occurs when `we && wmask[8] && wdata[8]`. The pushed value is wdata[7:0]. Config update and push may happen in the same write.
- **Full FIFO.** A push while full with no pop on the same edge:
  - the byte is dropped and the FIFO is unchanged;
  - tx_overflow is set.
- **Push and pop on the same edge.**
  - Level is unchanged.
  - If the FIFO was full, the push is accepted and no overflow is flagged.
  - If the FIFO was empty, no pop occurs; the push completes.
- **Pointers** are log2(FIFO_DEPTH) bits and wrap naturally. fifo_level is tracked separately.
- **Clear vs set.** If ovf_clr and a new overflow occur on the same edge, the set wins.
- **FSM states.** IDLE, WAIT_BUSY, WAIT_DONE.
  - IDLE: if `!fifo_empty && !tnsm_busy`, pop the head into tnsm_data, assert tnsm_start on the next cycle, and go to WAIT_BUSY.
  - WAIT_BUSY: if tnsm_busy=1, go to WAIT_DONE. If the counter reaches ACK_TIMEOUT, set ack_timeout and go to IDLE; the byte is considered lost.
  - WAIT_DONE: if tnsm_busy=0, go to IDLE.
- **tnsm_data** stays stable from launch until the next launch.

## Timing
- **Reset.** On arst_n=0 at a rising edge, on the next cycle:
  - all outputs are 0, except fifo_empty=1;
  - fifo_level=0 and the FSM is in IDLE;
  - FIFO contents are discarded.
- Reset mid-transfer aborts with no further tnsm_start.
- **Write visibility.** A write sampled at edge k is visible on outputs/level after edge k. All outputs are registered.
- **Launch latency.**
  - Push at edge k into an idle, empty block with tnsm_busy=0: the pop happens at edge k+1, and tnsm_start is high for exactly the cycle after edge k+1.
  - The earliest next launch is 1 cycle after returning to IDLE.
- **Pulse width.** tnsm_start is never high for two consecutive cycles.
- **Launch blocking.** No launch occurs while tnsm_busy=1 in IDLE, for example when the transmitter is driven externally.
- **Timeout.** The WAIT_BUSY counter counts cycles after the tnsm_start cycle. ack_timeout is set on the edge where the count equals ACK_TIMEOUT.

## Test plan
- **Reset.** Drive arst_n=0 for 2 cycles mid-traffic.
  - Required: fifo_empty=1, level=0, tnsm_start=0, config bits=0, stickies=0.
  - Required: no tnsm_start for 5 cycles after release.
- **Single send.** Write wmask=0x100, wdata=0x1A5. Model the transmitter to raise busy 1 cycle after start and hold it 10 cycles.
  - Required: tnsm_start pulse 2 edges after the write, tnsm_data=0xA5.
  - Required: level goes 1→0; FSM back in IDLE after busy falls.
- **Fill and overflow.** With tnsm_busy held 1, push 0x01..0x05.
  - Required: level=4, fifo_full=1, tx_overflow=1.
  - Required: on busy release, bytes launch in order 0x01..0x04; 0x05 is absent.
- **Simultaneous push/pop at full.** With the FIFO full and a launch due, push 0x77 on the same edge.
  - Required: level stays 4, tx_overflow stays 0, 0x77 is launched 4th after the current byte.
- **Masked config.** Write wmask=0xA00, wdata=0xE00.
  - Required: parity_en=1, loopback=1, parity_odd unchanged (0), no push.
- **Ack timeout.** Push 0x3C with tnsm_busy held 0 after start.
  - Required: ack_timeout=1 exactly ACK_TIMEOUT cycles after the tnsm_start cycle, FSM back in IDLE.
  - Required: ovf_clr clears ack_timeout.
